// File: rtl/d_cache.sv
// rtl/d_cache.sv - direct-mapped 4x4-word write-through, no-write-allocate data cache
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module d_cache (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  readM,
    input  logic                  writeM,
    input  logic [`WORD_SIZE-1:0] address,
    inout  wire  [15:0]           data,
    output logic                  ready,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [15:0]           mem_address,
    output logic [15:0]           mem_wdata,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           access_count,
    output logic [15:0]           hit_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_is_write;
    logic        r_first;
    logic        r_hit_first;
    logic [3:0]  r_valid;
    logic [11:0] r_tag [4];
    logic [15:0] r_line [16];
    logic [15:0] r_access_count;
    logic [15:0] r_hit_count;

    logic [1:0]  w_index;
    logic [11:0] w_tag;
    logic        w_hit;
    logic [15:0] w_word;
    logic        w_hit_inc;

    assign w_index = r_addr[3:2];
    assign w_tag   = r_addr[15:4];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_word  = r_line[{w_index, r_addr[1:0]}];

    // Writes complete in WRITE, so their first-lookup outcome is remembered in r_hit_first.
    assign w_hit_inc = (r_state == S_LOOKUP) ? r_first : r_hit_first;

    assign access_count = r_access_count;
    assign hit_count    = r_hit_count;

    assign data = (readM && ready && !r_is_write) ? w_word : 16'hzzzz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (readM || writeM) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (r_is_write)  w_next = S_WRITE;
                else if (w_hit)  w_next = S_IDLE;
                else             w_next = S_FILL;
            end
            S_FILL:   if (mem_ready) w_next = S_LOOKUP;
            S_WRITE:  if (mem_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 16'h0000;
        mem_wdata   = 16'h0000;
        case (r_state)
            S_LOOKUP: ready = !r_is_write && w_hit;
            S_FILL: begin
                mem_read    = 1'b1;
                mem_address = {r_addr[15:2], 2'b00};
            end
            S_WRITE: begin
                mem_write   = 1'b1;
                mem_address = r_addr;
                mem_wdata   = r_data;
                ready       = mem_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr         <= 16'h0000;
            r_data         <= 16'h0000;
            r_is_write     <= 1'b0;
            r_first        <= 1'b0;
            r_hit_first    <= 1'b0;
            r_valid        <= 4'b0000;
            r_access_count <= 16'h0000;
            r_hit_count    <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                r_tag[i] <= 12'h000;
            end
        end else begin
            if (r_state == S_IDLE && (readM || writeM)) begin
                r_addr     <= address;
                r_data     <= data;
                r_is_write <= writeM;
                r_first    <= 1'b1;
            end
            if (r_state == S_LOOKUP) begin
                r_first <= 1'b0;
                if (r_first) r_hit_first <= w_hit;
            end
            if (r_state == S_FILL && mem_ready) begin
                r_valid[w_index] <= 1'b1;
                r_tag[w_index]   <= w_tag;
            end
            if (ready) begin
                if (r_access_count != 16'hFFFF) r_access_count <= r_access_count + 16'd1;
                if (w_hit_inc && r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end
        end
    end

    // Line storage needs no reset: the valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL && mem_ready) begin
            for (int k = 0; k < 4; k++) begin
                r_line[{w_index, 2'(k)}] <= mem_rdata[16*k +: 16];
            end
        end else if (r_state == S_LOOKUP && r_is_write && w_hit) begin
            r_line[{w_index, r_addr[1:0]}] <= r_data;
        end
    end

endmodule

// File: tb/tb_d_cache.sv
// tb/tb_d_cache.sv - scoreboard bench for d_cache with a memory responder and reference cache model
module tb_d_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        readM = 1'b0;
    logic        writeM = 1'b0;
    logic [15:0] address = 16'h0000;
    wire  [15:0] data;
    logic        ready;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic [15:0] access_count;
    logic [15:0] hit_count;

    logic        tb_den = 1'b0;
    logic [15:0] tb_wd = 16'h0000;
    assign data = tb_den ? tb_wd : 16'hzzzz;

    d_cache dut (
        .clk(clk), .reset(reset), .readM(readM), .writeM(writeM), .address(address),
        .data(data), .ready(ready), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .access_count(access_count), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    logic [15:0] bmem [65536];
    logic [15:0] b0, b1, b2, b3;
    assign b0 = mem_address & 16'hFFFC;
    assign b1 = b0 + 16'd1;
    assign b2 = b0 + 16'd2;
    assign b3 = b0 + 16'd3;
    assign mem_rdata = {bmem[b3], bmem[b2], bmem[b1], bmem[b0]};

    typedef struct {
        bit          is_read;
        logic [15:0] dat;
        logic [15:0] acc;
        logic [15:0] hit;
        int          fills;
        int          wrs;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          fill_cnt = 0;
    int          wr_cnt = 0;
    bit          hold_mem = 1'b0;
    logic [15:0] cur_addr = 16'h0000;
    logic [15:0] cur_wd = 16'h0000;

    bit          m_valid [4];
    logic [11:0] m_tag [4];
    logic [15:0] m_acc = 16'h0000;
    logic [15:0] m_hit = 16'h0000;
    int          m_fills = 0;
    int          m_wrs = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: answers requests after a random delay and injects stray mem_ready pulses.
    int wcnt = 0;
    int dly = 1;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if ((mem_read || mem_write) && !hold_mem) begin
            check("mem_rw_exclusive", {15'd0, mem_read && mem_write}, 16'd0);
            if (wcnt >= dly) begin
                if (mem_read) begin
                    check("fill_address", mem_address, cur_addr & 16'hFFFC);
                    fill_cnt++;
                end else begin
                    check("write_address", mem_address, cur_addr);
                    check("write_wdata", mem_wdata, cur_wd);
                    wr_cnt++;
                    bmem[mem_address] = mem_wdata;
                end
                mem_ready = 1'b1;
                wcnt = 0;
                dly = $urandom_range(0, 3);
            end else begin
                wcnt++;
            end
        end else if (!mem_read && !mem_write && $urandom_range(0, 7) == 0) begin
            mem_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset && ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_ready: got ready=1 expected no pending access");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_read) check("read_data", data, e.dat);
                check("access_count", access_count, e.acc);
                check("hit_count", hit_count, e.hit);
                check("fill_count", 16'(fill_cnt), 16'(e.fills));
                check("write_count", 16'(wr_cnt), 16'(e.wrs));
            end
        end
    end

    task automatic access(input bit wr, input bit both, input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        int   idx;
        bit   hit;
        int   cyc;
        idx = int'(a[3:2]);
        hit = m_valid[idx] && (m_tag[idx] == a[15:4]);
        e.is_read = !wr;
        e.dat = bmem[a];
        e.acc = m_acc;
        e.hit = m_hit;
        if (!wr && !hit) begin
            m_fills++;
            m_valid[idx] = 1'b1;
            m_tag[idx] = a[15:4];
        end
        if (wr) m_wrs++;
        e.fills = m_fills;
        e.wrs = m_wrs;
        if (m_acc != 16'hFFFF) m_acc++;
        if (hit && m_hit != 16'hFFFF) m_hit++;
        sb.push_back(e);
        cur_addr = a;
        cur_wd = wd;
        @(negedge clk);
        readM = !wr || both;
        writeM = wr;
        address = a;
        tb_wd = wd;
        tb_den = wr;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready && cyc < 100);
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready after %0d cycles expected ready at %h", cyc, a);
        end
        if (!wr && hit) check("hit_latency", 16'(cyc), 16'd1);
        @(posedge clk);
        #1;
        readM = 1'b0;
        writeM = 1'b0;
        tb_den = 1'b0;
    endtask

    initial begin
        logic [11:0] tg;
        int          r;
        int          cyc;
        for (int i = 0; i < 65536; i++) bmem[i] = 16'($urandom);
        bmem[16'h0010] = 16'h000A;
        bmem[16'h0011] = 16'h000B;
        bmem[16'h0012] = 16'h000C;
        bmem[16'h0013] = 16'h000D;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = 12'h000;
        end

        #12;
        check("rst_ready", {15'd0, ready}, 16'd0);
        check("rst_mem_read", {15'd0, mem_read}, 16'd0);
        check("rst_mem_write", {15'd0, mem_write}, 16'd0);
        check("rst_mem_address", mem_address, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_access_count", access_count, 16'h0000);
        check("rst_hit_count", hit_count, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        access(1'b0, 1'b0, 16'h0013, 16'h0000);
        access(1'b0, 1'b0, 16'h0011, 16'h0000);
        access(1'b1, 1'b0, 16'h0012, 16'h55AA);
        access(1'b0, 1'b0, 16'h0012, 16'h0000);
        check("write_hit_readback", bmem[16'h0012], 16'h55AA);
        access(1'b1, 1'b0, 16'h0400, 16'h1234);
        access(1'b0, 1'b0, 16'h0400, 16'h0000);
        access(1'b0, 1'b0, 16'h0010, 16'h0000);
        access(1'b0, 1'b0, 16'h0050, 16'h0000);
        access(1'b0, 1'b0, 16'h0010, 16'h0000);
        access(1'b0, 1'b0, 16'h0011, 16'h0000);

        hold_mem = 1'b1;
        @(negedge clk);
        readM = 1'b1;
        address = 16'h0024;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!mem_read && cyc < 20);
        check("fill_started", {15'd0, mem_read}, 16'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_mem_read", {15'd0, mem_read}, 16'd0);
        check("abort_ready", {15'd0, ready}, 16'd0);
        check("abort_mem_address", mem_address, 16'h0000);
        check("abort_access_count", access_count, 16'h0000);
        check("abort_hit_count", hit_count, 16'h0000);
        @(negedge clk);
        readM = 1'b0;
        hold_mem = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_acc = 16'h0000;
        m_hit = 16'h0000;
        access(1'b0, 1'b0, 16'h0011, 16'h0000);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       tg = 12'h000;
                1:       tg = 12'h001;
                2:       tg = 12'h002;
                default: tg = 12'h005;
            endcase
            r = $urandom_range(0, 9);
            access(r < 3, r == 0, {tg, 4'($urandom_range(0, 15))}, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 16'(sb.size()), 16'd0);
        check("final_access_count", access_count, m_acc);
        check("final_hit_count", hit_count, m_hit);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
